// File: rtl/ieee754_normalize_pack_pkg.sv
// Shared constants, FSM encoding and helpers for the
// float adder back end (normalise, round, pack).
package ieee754_normalize_pack_pkg;

    localparam int unsigned BIAS = 127;
    localparam logic [7:0]  EXP_INF = 8'hFF;

    // Packed single-precision field positions.
    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MANT_MSB = 22;

    // Internal 32-bit fraction layout.
    localparam int unsigned FRAC_HIDDEN = 31;
    localparam int unsigned FRAC_LSB    = 8;
    localparam int unsigned FRAC_GUARD  = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Normalisation stops once the hidden bit is set, the
    // value is zero, or the exponent hits the subnormal floor.
    function automatic logic norm_stop(
        input logic [31:0] f,
        input logic [9:0]  e
    );
        return f[FRAC_HIDDEN] | (f == 32'd0) | (e <= 10'd1);
    endfunction

endpackage

// File: rtl/ieee754_normalize_pack_round.sv
// Round-to-nearest-even and single-precision packing of a
// normalised (or subnormal) fraction/exponent pair.
module ieee754_round_rne
    import ieee754_normalize_pack_pkg::*;
(
    input  logic [31:0] frac,
    input  logic        sticky,
    input  logic [9:0]  exp,
    input  logic        sgn,
    output logic [31:0] result,
    output logic        overflow,
    output logic        inexact
);

    logic        lsb;
    logic        guard;
    logic        stk;
    logic        up;
    logic [24:0] m;
    logic [9:0]  e;
    logic [22:0] mant;
    logic [7:0]  e_field;

    // Rounding increment, mantissa carry-out and final encoding.
    always_comb begin
        lsb      = frac[FRAC_LSB];
        guard    = frac[FRAC_GUARD];
        stk      = (|frac[6:0]) | sticky;
        up       = guard & (stk | lsb);
        m        = {1'b0, frac[31:8]} + {24'd0, up};
        mant     = m[22:0];
        e        = exp;
        result   = 32'd0;
        overflow = 1'b0;
        inexact  = guard | stk;
        if (m[24]) begin
            mant = 23'd0;
            e    = exp + 10'd1;
        end
        // A subnormal that did not round up into the hidden bit
        // keeps a zero exponent field.
        if (e == 10'd1 && !m[23] && !m[24]) begin
            e_field = 8'd0;
        end else begin
            e_field = e[7:0];
        end
        if (frac == 32'd0 && !sticky) begin
            result  = {sgn, 31'd0};
            inexact = 1'b0;
        end else if (e >= 10'd255) begin
            result   = {sgn, EXP_INF, 23'd0};
            overflow = 1'b1;
            inexact  = 1'b1;
        end else begin
            result = {sgn, e_field, mant};
        end
    end

endmodule

// File: rtl/ieee754_normalize_pack.sv
// Float adder back end: iterative left-normalisation, then
// RNE rounding and packing, with valid/ready on both sides.
module ieee754_normalize_pack
    import ieee754_normalize_pack_pkg::*;
#(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic        carry,
    input  logic [31:0] fraction,
    input  logic [31:0] exponent,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] float,
    output logic        overflow,
    output logic        inexact
);

    state_t      state;
    state_t      state_n;
    logic [31:0] frac_q;
    logic [9:0]  exp_q;
    logic        sticky_q;
    logic        sgn_q;
    logic [31:0] frac_sh;
    logic [9:0]  exp_sh;
    logic [31:0] rnd_float;
    logic        rnd_ovf;
    logic        rnd_inx;
    logic        accept;
    logic        unused_exp_hi;

    assign in_ready      = (state == S_IDLE);
    assign accept        = in_valid & in_ready;
    assign unused_exp_hi = ^exponent[31:8];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (accept) state_n = S_NORM;
            S_NORM:  if (norm_stop(frac_q, exp_q)) state_n = S_ROUND;
            S_ROUND: state_n = S_DONE;
            S_DONE:  if (out_ready) state_n = S_IDLE;
        endcase
    end

    // Up to SHIFT_PER_CYCLE individually gated shift steps.
    always_comb begin
        frac_sh = frac_q;
        exp_sh  = exp_q;
        for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
            if (!norm_stop(frac_sh, exp_sh)) begin
                frac_sh = {frac_sh[30:0], 1'b0};
                exp_sh  = exp_sh - 10'd1;
            end
        end
    end

    // Operand load, carry pre-shift and normalisation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_q   <= 32'd0;
            exp_q    <= 10'd0;
            sticky_q <= 1'b0;
            sgn_q    <= 1'b0;
        end else if (accept) begin
            sgn_q <= sign;
            if (carry) begin
                frac_q   <= {1'b1, fraction[31:1]};
                sticky_q <= fraction[0];
                exp_q    <= {2'b00, exponent[7:0]} + 10'd1;
            end else begin
                frac_q   <= fraction;
                sticky_q <= 1'b0;
                exp_q    <= {2'b00, exponent[7:0]};
            end
        end else if (state == S_NORM) begin
            frac_q <= frac_sh;
            exp_q  <= exp_sh;
        end
    end

    // Result registers, held through DONE until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            float     <= 32'd0;
            overflow  <= 1'b0;
            inexact   <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == S_ROUND) begin
            float     <= rnd_float;
            overflow  <= rnd_ovf;
            inexact   <= rnd_inx;
            out_valid <= 1'b1;
        end else if (state == S_DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    ieee754_round_rne u_round (
        .frac     (frac_q),
        .sticky   (sticky_q),
        .exp      (exp_q),
        .sgn      (sgn_q),
        .result   (rnd_float),
        .overflow (rnd_ovf),
        .inexact  (rnd_inx)
    );

endmodule

// File: tb/tb_ieee754_normalize_pack.sv
// Directed bench for ieee754_normalize_pack, running the
// 1-step and 8-step shifter variants in lockstep.
module tb_ieee754_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        sign = 1'b0;
    logic        carry = 1'b0;
    logic [31:0] fraction = 32'd0;
    logic [31:0] exponent = 32'd0;
    logic        out_ready = 1'b0;

    logic        rdy1, ov1, of1, ix1;
    logic [31:0] f1;
    logic        rdy8, ov8, of8, ix8;
    logic [31:0] f8;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] cf1, cf8;
    logic        co1, co8, ci1, ci8;
    int          lat1, lat8;

    always #5 clk = ~clk;

    ieee754_normalize_pack #(.SHIFT_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy1),
        .sign(sign), .carry(carry),
        .fraction(fraction), .exponent(exponent),
        .out_valid(ov1), .out_ready(out_ready),
        .float(f1), .overflow(of1), .inexact(ix1)
    );

    ieee754_normalize_pack #(.SHIFT_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy8),
        .sign(sign), .carry(carry),
        .fraction(fraction), .exponent(exponent),
        .out_valid(ov8), .out_ready(out_ready),
        .float(f8), .overflow(of8), .inexact(ix8)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Latency counts the accept edge as 1, so a result seen
    // after the second following edge has latency 3.
    task automatic run_op(input logic s, input logic c,
                          input logic [31:0] fr,
                          input logic [31:0] ex, input int hold);
        bit got1 = 0;
        bit got8 = 0;
        int lat = 1;
        @(negedge clk);
        sign = s; carry = c; fraction = fr; exponent = ex;
        in_valid = 1'b1;
        chk("in_ready_idle", {rdy1, rdy8}, 2'b11);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat1 = 0; lat8 = 0;
        while (!(got1 && got8) && lat < 200) begin
            @(posedge clk);
            #1 lat++;
            if (ov1 && !got1) begin
                got1 = 1; lat1 = lat;
                cf1 = f1; co1 = of1; ci1 = ix1;
            end
            if (ov8 && !got8) begin
                got8 = 1; lat8 = lat;
                cf8 = f8; co8 = of8; ci8 = ix8;
            end
        end
        chk("done_in_time", {31'd0, got1 & got8}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold_float_%0d", i), f1, cf1);
            chk($sformatf("hold_flags_%0d", i),
                {ov1, rdy1, ix1}, {1'b1, 1'b0, ci1});
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("out_valid_cleared", {ov1, ov8}, 2'b00);
    endtask

    task automatic chk_res(input string tag, input logic [31:0] ef,
                           input logic eo, input logic ei);
        chk({tag, "_float1"}, cf1, ef);
        chk({tag, "_float8"}, cf8, ef);
        chk({tag, "_ovf"}, {co1, co8}, {eo, eo});
        chk({tag, "_inx"}, {ci1, ci8}, {ei, ei});
    endtask

    initial begin
        #2;
        chk("reset_float", f1, 32'd0);
        chk("reset_flags", {ov1, of1, ix1, rdy1}, 4'b0001);
        chk("reset_ready8", {31'd0, rdy8}, 32'd1);
        @(negedge clk) rst_n = 1'b1;

        run_op(0, 0, 32'h8000_0000, 32'd127, 0);
        chk_res("one", 32'h3F80_0000, 0, 0);
        chk("one_lat1", lat1, 3);
        chk("one_lat8", lat8, 3);

        run_op(0, 1, 32'h0000_0000, 32'd127, 0);
        chk_res("two", 32'h4000_0000, 0, 0);

        run_op(1, 1, 32'h0000_0000, 32'd127, 0);
        chk_res("negtwo", 32'hC000_0000, 0, 0);

        run_op(0, 0, 32'h0080_0000, 32'd127, 0);
        chk_res("shift8", 32'h3B80_0000, 0, 0);
        chk("shift8_lat1", lat1, 11);
        chk("shift8_lat8", lat8, 4);

        run_op(0, 0, 32'h8000_0080, 32'd127, 0);
        chk_res("tie_even", 32'h3F80_0000, 0, 1);

        run_op(0, 0, 32'h8000_0180, 32'd127, 0);
        chk_res("tie_odd", 32'h3F80_0002, 0, 1);

        run_op(0, 0, 32'hFFFF_FF80, 32'd127, 0);
        chk_res("rnd_carry", 32'h4000_0000, 0, 1);

        run_op(1, 1, 32'h0000_0000, 32'd254, 0);
        chk_res("overflow", 32'hFF80_0000, 1, 1);

        run_op(0, 0, 32'h4000_0000, 32'd1, 0);
        chk_res("subnormal", 32'h0040_0000, 0, 0);

        run_op(1, 0, 32'h0000_0000, 32'd127, 0);
        chk_res("neg_zero", 32'h8000_0000, 0, 0);

        run_op(0, 0, 32'h8000_0180, 32'd127, 5);
        chk_res("hold", 32'h3F80_0002, 0, 1);

        // Abort a long normalisation with an async reset.
        @(negedge clk);
        sign = 0; carry = 0; fraction = 32'h0000_0001;
        exponent = 32'd127; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {rdy1, rdy8}, 2'b11);
        chk("rst_out_valid", {ov1, ov8}, 2'b00);
        chk("rst_float", f1, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op(0, 0, 32'h8000_0000, 32'd127, 0);
        chk_res("after_rst", 32'h3F80_0000, 0, 0);
        chk("after_rst_lat", lat1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
